// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and port owner polarity.
// Owner values match the address mux select (0 = fetch PC, 1 = data address).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_latency_counter.sv
// Loadable down-counter with zero flag, used to time the memory access latency.
module arb_latency_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer/arbiter for the multicycle MIPS datapath.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  output logic         if_done,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_wdata,
  output logic         d_done,
  output logic         addr_sel,
  output logic         ram_en,
  output logic         ram_we,
  output logic [N-1:0] ram_wdata,
  input  logic [N-1:0] ram_rdata,
  output logic [N-1:0] rdata,
  output logic         busy
);

  localparam int unsigned CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  state_t        state, state_n;
  logic          req_any;
  logic          grant_d;
  logic          we_l;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt;

  assign req_any = if_req | d_req;

`ifdef ARB_RR_EN
  logic rr_last;

  // On a tie the side that did not own the port last time wins.
  always_comb begin
    if (if_req && d_req)
      grant_d = (rr_last == OWN_IF);
    else
      grant_d = d_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_last <= OWN_IF;
    else if (state == IDLE && req_any)
      rr_last <= grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  arb_latency_counter #(
    .W(CW)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(CNT_INIT),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Memory strobes are decoded from state so an async reset drops them at once.
  always_comb begin
    state_n  = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    if_done  = 1'b0;
    d_done   = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req_any) begin
          state_n  = ACCESS;
          cnt_load = 1'b1;
        end
      end
      ACCESS: begin
        ram_en = 1'b1;
        ram_we = (addr_sel == OWN_D) && we_l;
        if (cnt_zero)
          state_n = DONE;
        else
          cnt_dec = 1'b1;
      end
      DONE: begin
        if_done = (addr_sel == OWN_IF);
        d_done  = (addr_sel == OWN_D);
        state_n = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sel  <= OWN_IF;
      we_l      <= 1'b0;
      ram_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        addr_sel <= grant_d;
        if (grant_d == OWN_D) begin
          we_l      <= d_we;
          ram_wdata <= d_wdata;
        end
      end
      if (state == ACCESS && cnt_zero && !((addr_sel == OWN_D) && we_l))
        rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 instance for the main scenarios,
// LAT=1 instance for back-to-back fetches.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        if_req, d_req, d_we;
  logic [31:0] d_wdata, ram_rdata;
  logic        if_done, d_done, addr_sel, ram_en, ram_we, busy;
  logic [31:0] ram_wdata, rdata;

  logic        if_req1, d_req1, d_we1;
  logic [31:0] d_wdata1, ram_rdata1;
  logic        if_done1, d_done1, addr_sel1, ram_en1, ram_we1, busy1;
  logic [31:0] ram_wdata1, rdata1;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(32), .LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_wdata(d_wdata), .d_done(d_done),
    .addr_sel(addr_sel), .ram_en(ram_en), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rdata(rdata), .busy(busy)
  );

  mem_port_arbiter #(.N(32), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_done(if_done1),
    .d_req(d_req1), .d_we(d_we1), .d_wdata(d_wdata1), .d_done(d_done1),
    .addr_sel(addr_sel1), .ram_en(ram_en1), .ram_we(ram_we1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .rdata(rdata1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with requests set up; ends in the DONE cycle.
  task automatic txn(input string tag, input logic own, input logic wr, input logic [31:0] exp_rd);
    step();
    check({tag, ".acc1.busy"}, {31'b0, busy}, 32'd1);
    check({tag, ".acc1.en"}, {31'b0, ram_en}, 32'd1);
    check({tag, ".acc1.sel"}, {31'b0, addr_sel}, {31'b0, own});
    check({tag, ".acc1.we"}, {31'b0, ram_we}, {31'b0, own & wr});
    step();
    check({tag, ".acc2.en"}, {31'b0, ram_en}, 32'd1);
    check({tag, ".acc2.we"}, {31'b0, ram_we}, {31'b0, own & wr});
    check({tag, ".acc2.done"}, {30'b0, if_done, d_done}, 32'd0);
    step();
    check({tag, ".done.en"}, {31'b0, ram_en}, 32'd0);
    check({tag, ".done.if"}, {31'b0, if_done}, {31'b0, ~own});
    check({tag, ".done.d"}, {31'b0, d_done}, {31'b0, own});
    check({tag, ".done.rdata"}, rdata, exp_rd);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; d_wdata = '0; ram_rdata = '0;
    if_req1 = 0; d_req1 = 0; d_we1 = 0; d_wdata1 = '0; ram_rdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.en", {31'b0, ram_en}, 32'd0);
    check("rst.we", {31'b0, ram_we}, 32'd0);
    check("rst.sel", {31'b0, addr_sel}, 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.wdata", ram_wdata, 32'd0);
    check("rst.done", {30'b0, if_done, d_done}, 32'd0);
    rst_n = 1'b1;

    // Fetch read
    ram_rdata = 32'h2002_0005;
    if_req = 1;
    txn("fetch", 1'b0, 1'b0, 32'h2002_0005);
    if_req = 0;
    step();
    check("fetch.idle.busy", {31'b0, busy}, 32'd0);
    check("fetch.idle.done", {31'b0, if_done}, 32'd0);

    // Data write leaves rdata alone
    ram_rdata = 32'h1111_1111;
    d_req = 1; d_we = 1; d_wdata = 32'hDEAD_BEEF;
    txn("dwrite", 1'b1, 1'b1, 32'h2002_0005);
    check("dwrite.wdata", ram_wdata, 32'hDEAD_BEEF);
    d_req = 0; d_we = 0; d_wdata = '0;
    step();
    check("dwrite.idle.sel_hold", {31'b0, addr_sel}, 32'd1);
    check("dwrite.idle.we", {31'b0, ram_we}, 32'd0);

    // Fresh reset so round-robin history starts at fetch
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();

`ifdef ARB_RR_EN
    if_req = 1; d_req = 1;
    ram_rdata = 32'hA000_0001;
    txn("rr1", 1'b1, 1'b0, 32'hA000_0001);
    step();
    ram_rdata = 32'hA000_0002;
    txn("rr2", 1'b0, 1'b0, 32'hA000_0002);
    step();
    ram_rdata = 32'hA000_0003;
    txn("rr3", 1'b1, 1'b0, 32'hA000_0003);
    step();
    ram_rdata = 32'hA000_0004;
    txn("rr4", 1'b0, 1'b0, 32'hA000_0004);
    if_req = 0; d_req = 0;
    step();
`else
    if_req = 1; d_req = 1;
    ram_rdata = 32'hA000_0001;
    txn("fix1", 1'b1, 1'b0, 32'hA000_0001);
    step();
    ram_rdata = 32'hA000_0002;
    txn("fix2", 1'b1, 1'b0, 32'hA000_0002);
    d_req = 0;
    step();
    ram_rdata = 32'hA000_0003;
    txn("fix3", 1'b0, 1'b0, 32'hA000_0003);
    if_req = 0; d_req = 1;
    step();
    ram_rdata = 32'hA000_0004;
    txn("fix4", 1'b1, 1'b0, 32'hA000_0004);
    d_req = 0;
    step();
`endif

    // Reset in the second ACCESS cycle aborts the transaction
    ram_rdata = 32'hCAFE_0001;
    if_req = 1;
    step();
    step();
    check("abort.pre.en", {31'b0, ram_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.en", {31'b0, ram_en}, 32'd0);
    check("abort.we", {31'b0, ram_we}, 32'd0);
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.sel", {31'b0, addr_sel}, 32'd0);
    check("abort.rdata", rdata, 32'd0);
    check("abort.wdata", ram_wdata, 32'd0);
    check("abort.done", {30'b0, if_done, d_done}, 32'd0);
    if_req = 0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort.after.done", {30'b0, if_done, d_done}, 32'd0);
      check("abort.after.busy", {31'b0, busy}, 32'd0);
    end

    // LAT=1: held fetch request completes every 3 cycles
    ram_rdata1 = 32'h0BAD_F00D;
    if_req1 = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check("lat1.en", {31'b0, ram_en1}, {31'b0, (i % 3) == 1});
      check("lat1.done", {31'b0, if_done1}, {31'b0, (i % 3) == 2});
      check("lat1.busy", {31'b0, busy1}, {31'b0, (i % 3) != 0});
      check("lat1.sel_we_dd", {29'b0, addr_sel1, ram_we1, d_done1}, 32'd0);
      if ((i % 3) == 2)
        check("lat1.rdata", rdata1, 32'h0BAD_F00D);
    end
    if_req1 = 0;
    step();
    check("lat1.wdata", ram_wdata1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
